// File: rtl/serial_frame_rx.sv
// Serial framed-word receiver: start bit, DATA_W data bits LSB first,
// optional parity bit (enabled by defining PARITY_EN), then a stop bit.
// Each good word is presented on q_data/q_valid through a 1-entry buffer.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] q_data,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic              q_valid_q, q_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              par_ok;
  logic              word_good;

`ifdef PARITY_EN
  logic par_q, par_d;
  logic par_err_q, par_err_d;

  // Even parity: the parity bit equals the XOR of the data bits.
  assign par_ok  = ((^shreg_q) == par_q);
  assign par_err = par_err_q;

  // Parity sample and parity error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  // Capture the parity bit in PAR; flag a mismatch on the STOP edge.
  always_comb begin
    par_d     = par_q;
    par_err_d = 1'b0;
    if (state_q == PAR) begin
      par_d = d;
    end
    if (state_q == STOP) begin
      par_err_d = ~par_ok;
    end
  end
`else
  assign par_ok  = 1'b1;
  assign par_err = 1'b0;
`endif

  // A word is good when its stop bit is 0 and parity (if any) matches.
  assign word_good = (state_q == STOP) && !d && par_ok;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      q_data_q    <= '0;
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      q_data_q    <= q_data_d;
      q_valid_q   <= q_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, deserializer and output-buffer logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    q_data_d    = q_data_q;
    q_valid_d   = q_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (d) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shreg_d[cnt_q] = d;
        if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAR: begin
        state_d = STOP;
      end
      STOP: begin
        // A 1 here is a framing error, never a new start bit.
        frame_err_d = d;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output buffer: load when empty or being drained this edge,
    // otherwise drop the new word and latch overrun.
    if (word_good) begin
      if (!q_valid_q || q_ready) begin
        q_data_d  = shreg_q;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  assign q_data    = q_data_q;
  assign q_valid   = q_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
